// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply / divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign applied in the DONE cycle.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    // Handshake: a start is any edge with ctrl_MULT|ctrl_DIV high (MULT wins);
    // data_resultRDY is a one-cycle pulse and data_result/data_exception hold
    // until the next completion. busy is high whenever state_q is not IDLE.
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_mag_q, b_mag_q, hi_q, lo_q;
    logic               neg_q;
    logic               start, last_iter;
    logic [WIDTH-1:0]   a_abs, b_abs;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign last_iter = (cnt_q == CNT_W'(ITER - 1));
    assign a_abs     = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign b_abs     = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    assign busy      = (state_q != S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       state_d = S_IDLE;
            S_MUL, S_DIV: if (last_iter) state_d = S_DONE;
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
        if (start) state_d = ctrl_MULT ? S_MUL : S_DIV;
    end

    // Shared adder: multiply adds |A| into the high half; divide subtracts
    // |B| from the partial remainder shifted left by one (33-bit operand).
    logic [WIDTH+1:0] add_x, add_y, add_res;
    logic             add_sub;

    always_comb begin
        add_x   = {2'b00, hi_q};
        add_y   = {2'b00, a_mag_q};
        add_sub = 1'b0;
        if (state_q == S_DIV) begin
            add_x   = {1'b0, hi_q, lo_q[WIDTH-1]};
            add_y   = {2'b00, b_mag_q};
            add_sub = 1'b1;
        end
        add_res = add_sub ? (add_x - add_y) : (add_x + add_y);
    end

    logic [WIDTH:0] mul_t;
    logic           div_ge;

    assign mul_t  = lo_q[0] ? add_res[WIDTH:0] : {1'b0, hi_q};
    assign div_ge = ~add_res[WIDTH+1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
        end else if (start) begin
            cnt_q   <= '0;
            a_mag_q <= a_abs;
            b_mag_q <= b_abs;
            hi_q    <= '0;
            lo_q    <= ctrl_MULT ? b_abs : a_abs;
            neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        end else if (state_q == S_MUL) begin
            cnt_q <= cnt_q + 1'b1;
            hi_q  <= mul_t[WIDTH:1];
            lo_q  <= {mul_t[0], lo_q[WIDTH-1:1]};
        end else if (state_q == S_DIV) begin
            cnt_q <= cnt_q + 1'b1;
            hi_q  <= div_ge ? add_res[WIDTH-1:0] : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            lo_q  <= {lo_q[WIDTH-2:0], div_ge};
        end
    end

    // Which operation finished is remembered by the state that preceded DONE.
    logic             was_div_q;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quot_s;
    logic             mul_exc, div_exc, b_zero;

    assign prod_s  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign mul_exc = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
    assign quot_s  = neg_q ? -lo_q : lo_q;
    assign b_zero  = (b_mag_q == '0);
    // A positive quotient with the top bit set only arises from MIN / -1.
    assign div_exc = b_zero | (~neg_q & lo_q[WIDTH-1]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            was_div_q      <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            if (state_q == S_MUL)      was_div_q <= 1'b0;
            else if (state_q == S_DIV) was_div_q <= 1'b1;
            data_resultRDY <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                if (was_div_q) begin
                    data_result    <= b_zero ? '0 : quot_s;
                    data_exception <= div_exc;
                end else begin
                    data_result    <= prod_s[WIDTH-1:0];
                    data_exception <= mul_exc;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: expected {exception,result} and the
// completion edge are queued at each start and popped on data_resultRDY.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int failures = 0;
    int rdy_count = 0;
    logic [32:0] exp_q[$];
    int          exp_edge_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_div);
        longint      p;
        logic [63:0] pu;
        int          q;
        if (!is_div) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            pu = p;
            return {pu[63:32] != {32{pu[31]}}, pu[31:0]};
        end
        if (b == 32'h0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    always @(negedge clock) begin
        if (data_resultRDY) begin
            rdy_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", 64'd1, 64'd0);
            end else begin
                logic [32:0] e;
                int          ee;
                e  = exp_q.pop_front();
                ee = exp_edge_q.pop_front();
                check("result", {32'h0, data_result}, {32'h0, e[31:0]});
                check("exception", {63'h0, data_exception}, {63'h0, e[32]});
                check("latency_edge", 64'(edge_cnt), 64'(ee));
            end
        end
    end

    // Drives a one-cycle start pulse; returns at the negedge after E0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic m, input logic d);
        int e0;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        e0 = edge_cnt + 1;
        while (exp_edge_q.size() > 0 && exp_edge_q[$] > e0) begin
            void'(exp_edge_q.pop_back());
            void'(exp_q.pop_back());
        end
        if (reset && (m || d)) begin
            exp_q.push_back(model(a, b, !m));
            exp_edge_q.push_back(e0 + 33);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
            #1;
        end
        check("done_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Full op with busy profile: high from after E0 through E32, low after E33.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic d);
        int bad;
        bad = 0;
        start_op(a, b, !d, d);
        if (busy !== 1'b1) bad++;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clock);
            if (busy !== 1'b1) bad++;
        end
        check("busy_in_flight_errs", 64'(bad), 64'd0);
        @(negedge clock);
        check("busy_after_done", {63'h0, busy}, 64'd0);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int rc;
        repeat (3) @(negedge clock);
        check("rst_result", {32'h0, data_result}, 64'd0);
        check("rst_exception", {63'h0, data_exception}, 64'd0);
        check("rst_rdy", {63'h0, data_resultRDY}, 64'd0);
        check("rst_busy", {63'h0, busy}, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        run_op(32'h0000_0006, 32'hFFFF_FFF9, 1'b0);
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0);
        run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        run_op(32'd100, 32'd7, 1'b1);
        run_op(32'd5, 32'd0, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            if (i % 4 == 1) a = 32'($urandom_range(0, 100000));
            run_op(a, b, i[0]);
        end

        // Abort a multiply by a divide ten cycles in.
        rc = rdy_count;
        start_op(32'd3, 32'd4, 1'b1, 1'b0);
        repeat (8) @(negedge clock);
        start_op(32'd100, 32'd7, 1'b0, 1'b1);
        wait_done();
        repeat (5) @(negedge clock);
        check("restart_pulses", 64'(rdy_count - rc), 64'd1);

        // Back-to-back: new start in the DONE cycle, both starts high.
        start_op(32'd9, 32'hFFFF_FFFD, 1'b0, 1'b1);
        repeat (31) @(negedge clock);
        start_op(32'd3, 32'd4, 1'b1, 1'b1);
        wait_done();

        // Reset in the middle of a multiply.
        start_op(32'h1234_5678, 32'h0000_0013, 1'b1, 1'b0);
        repeat (19) @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_rst_result", {32'h0, data_result}, 64'd0);
        check("mid_rst_exception", {63'h0, data_exception}, 64'd0);
        check("mid_rst_busy", {63'h0, busy}, 64'd0);
        check("mid_rst_rdy", {63'h0, data_resultRDY}, 64'd0);
        exp_q.delete();
        exp_edge_q.delete();
        start_op(32'd2, 32'd2, 1'b1, 1'b0);
        reset = 1'b1;
        rc = rdy_count;
        repeat (50) @(negedge clock);
        check("no_rdy_after_reset", 64'(rdy_count - rc), 64'd0);
        check("idle_after_reset", {63'h0, busy}, 64'd0);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
